// File: rtl/if_queue.sv
// if_queue: four-entry instruction fetch queue between fetch and decode.
//
// The queue is a circular FIFO of {PC, Instr} pairs. Fetch pushes when it
// presents a valid entry and the queue has room. Decode pops the head unless
// it stalls. Flush empties the queue on a redirect. There is no bypass path,
// so an entry pushed at one edge is visible to decode only after that edge.
//
// Ports:
//   Clk      in   system clock, rising-edge active
//   Reset    in   synchronous active-high reset
//   F_Valid  in   fetch presents an entry this cycle
//   F_PC     in   [31:0] PC of the presented entry
//   F_Instr  in   [31:0] instruction word of the presented entry
//   F_Ready  out  queue can accept an entry (Count < 4)
//   D_Valid  out  head entry is valid (Count != 0)
//   D_PC     out  [31:0] head PC, zero when empty
//   D_Instr  out  [31:0] head instruction, zero (NOP) when empty
//   D_PC8    out  [31:0] D_PC + 8 with 32-bit wrap
//   D_Stall  in   decode cannot consume the head this cycle
//   Flush    in   discard every queued entry at the next edge
//   Count    out  [2:0] number of entries held, 0..4
module if_queue (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        F_Valid,
    input  logic [31:0] F_PC,
    input  logic [31:0] F_Instr,
    output logic        F_Ready,
    output logic        D_Valid,
    output logic [31:0] D_PC,
    output logic [31:0] D_Instr,
    output logic [31:0] D_PC8,
    input  logic        D_Stall,
    input  logic        Flush,
    output logic [2:0]  Count
);

    logic [31:0] pc_mem_q    [4];
    logic [31:0] pc_mem_d    [4];
    logic [31:0] instr_mem_q [4];
    logic [31:0] instr_mem_d [4];
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  count_q,  count_d;
    logic        push;
    logic        pop;

    assign F_Ready = (count_q < 3'd4);
    assign D_Valid = (count_q != 3'd0);
    assign Count   = count_q;

    // Empty queue presents a zero PC and a NOP so decode sees clean values.
    assign D_PC    = D_Valid ? pc_mem_q[rd_ptr_q]    : 32'h0000_0000;
    assign D_Instr = D_Valid ? instr_mem_q[rd_ptr_q] : 32'h0000_0000;
    assign D_PC8   = D_PC + 32'd8;

    // F_Ready depends only on the registered count, so a pop in the same
    // cycle never opens room for a push when the queue is full.
    assign push = F_Valid && F_Ready && !Flush;
    assign pop  = D_Valid && !D_Stall && !Flush;

    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        if (Flush) begin
            rd_ptr_d = 2'd0;
            wr_ptr_d = 2'd0;
            count_d  = 3'd0;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]    = F_PC;
                instr_mem_d[wr_ptr_q] = F_Instr;
                wr_ptr_d              = wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 2'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is never observable while empty, so it carries no reset.
    always_ff @(posedge Clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end

`ifndef SYNTHESIS
    count_in_range: assert property (@(posedge Clk) disable iff (Reset)
        count_q <= 3'd4);

    // Pointer difference must agree with the count; full and empty both
    // give equal pointers, distinguished only by the count.
    count_matches_ptrs: assert property (@(posedge Clk) disable iff (Reset)
        count_q[1:0] == 2'(wr_ptr_q - rd_ptr_q));
`endif

endmodule

// File: tb/tb_if_queue.sv
// tb_if_queue: directed self-checking bench for if_queue.
module tb_if_queue;

    logic        Clk;
    logic        Reset;
    logic        F_Valid;
    logic [31:0] F_PC;
    logic [31:0] F_Instr;
    logic        F_Ready;
    logic        D_Valid;
    logic [31:0] D_PC;
    logic [31:0] D_Instr;
    logic [31:0] D_PC8;
    logic        D_Stall;
    logic        Flush;
    logic [2:0]  Count;

    int checks = 0;
    int errors = 0;

    if_queue dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .F_Valid (F_Valid),
        .F_PC    (F_PC),
        .F_Instr (F_Instr),
        .F_Ready (F_Ready),
        .D_Valid (D_Valid),
        .D_PC    (D_PC),
        .D_Instr (D_Instr),
        .D_PC8   (D_PC8),
        .D_Stall (D_Stall),
        .Flush   (Flush),
        .Count   (Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset;
        Reset   = 1'b1;
        F_Valid = 1'b0;
        D_Stall = 1'b0;
        Flush   = 1'b0;
        tick;
        Reset = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1; F_Valid = 1'b0; F_PC = '0; F_Instr = '0;
        D_Stall = 1'b0; Flush = 1'b0;
        tick; tick;
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", Count); end
        checks++; if (F_Ready !== 1'b1) begin errors++; $display("FAIL reset_f_ready got %b exp 1", F_Ready); end
        checks++; if (D_Valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid got %b exp 0", D_Valid); end
        checks++; if (D_PC !== 32'h0) begin errors++; $display("FAIL reset_d_pc got %h exp 0", D_PC); end
        checks++; if (D_Instr !== 32'h0) begin errors++; $display("FAIL reset_d_instr got %h exp 0", D_Instr); end
        checks++; if (D_PC8 !== 32'h8) begin errors++; $display("FAIL reset_d_pc8 got %h exp 8", D_PC8); end
        Reset = 1'b0;
    endtask

    task automatic test_basic;
        do_reset;
        F_Valid = 1'b1; F_PC = 32'h3000; F_Instr = 32'h2408_0001;
        #1;
        checks++; if (D_Valid !== 1'b0) begin errors++; $display("FAIL basic_no_bypass got %b exp 0", D_Valid); end
        tick;
        checks++; if (D_Valid !== 1'b1) begin errors++; $display("FAIL basic_valid1 got %b exp 1", D_Valid); end
        checks++; if (D_PC !== 32'h3000) begin errors++; $display("FAIL basic_pc1 got %h exp 3000", D_PC); end
        checks++; if (D_PC8 !== 32'h3008) begin errors++; $display("FAIL basic_pc8_1 got %h exp 3008", D_PC8); end
        checks++; if (D_Instr !== 32'h2408_0001) begin errors++; $display("FAIL basic_instr1 got %h exp 24080001", D_Instr); end
        F_PC = 32'h3004; F_Instr = 32'h2409_0002;
        tick;
        F_Valid = 1'b0;
        checks++; if (D_PC !== 32'h3004) begin errors++; $display("FAIL basic_pc2 got %h exp 3004", D_PC); end
        checks++; if (D_PC8 !== 32'h300C) begin errors++; $display("FAIL basic_pc8_2 got %h exp 300c", D_PC8); end
        checks++; if (D_Instr !== 32'h2409_0002) begin errors++; $display("FAIL basic_instr2 got %h exp 24090002", D_Instr); end
        checks++; if (Count !== 3'd1) begin errors++; $display("FAIL basic_count_mid got %0d exp 1", Count); end
        tick;
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL basic_count_end got %0d exp 0", Count); end
        checks++; if (D_Valid !== 1'b0) begin errors++; $display("FAIL basic_valid_end got %b exp 0", D_Valid); end
    endtask

    task automatic test_full_stall;
        do_reset;
        D_Stall = 1'b1; F_Valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            F_PC = 32'h3000 + 32'(4 * i); F_Instr = 32'hA000_0000 + 32'(i);
            tick;
            if (i == 3) begin
                checks++; if (Count !== 3'd4) begin errors++; $display("FAIL full_count4 got %0d exp 4", Count); end
                checks++; if (F_Ready !== 1'b0) begin errors++; $display("FAIL full_f_ready got %b exp 0", F_Ready); end
            end
        end
        checks++; if (Count !== 3'd4) begin errors++; $display("FAIL full_fifth_dropped got %0d exp 4", Count); end
        checks++; if (D_PC !== 32'h3000) begin errors++; $display("FAIL full_head got %h exp 3000", D_PC); end
        // Full with a pop and a push request: pop only.
        D_Stall = 1'b0; F_PC = 32'h5000; F_Instr = 32'h5555_5555;
        tick;
        F_Valid = 1'b0;
        checks++; if (Count !== 3'd3) begin errors++; $display("FAIL full_pop_no_push got %0d exp 3", Count); end
        for (int i = 1; i < 4; i++) begin
            checks++; if (D_PC !== 32'h3000 + 32'(4 * i)) begin errors++; $display("FAIL full_drain_pc got %h exp %h", D_PC, 32'h3000 + 32'(4 * i)); end
            checks++; if (D_Instr !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL full_drain_instr got %h exp %h", D_Instr, 32'hA000_0000 + 32'(i)); end
            tick;
        end
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL full_drained got %0d exp 0", Count); end
        checks++; if (D_Valid !== 1'b0) begin errors++; $display("FAIL full_drained_valid got %b exp 0", D_Valid); end
    endtask

    task automatic test_back_to_back;
        do_reset;
        D_Stall = 1'b1; F_Valid = 1'b1;
        F_PC = 32'h6000; F_Instr = 32'h6000; tick;
        F_PC = 32'h6004; F_Instr = 32'h6004; tick;
        checks++; if (Count !== 3'd2) begin errors++; $display("FAIL b2b_prefill got %0d exp 2", Count); end
        D_Stall = 1'b0;
        for (int k = 0; k < 6; k++) begin
            F_PC = 32'h6000 + 32'(4 * (k + 2)); F_Instr = F_PC;
            checks++; if (D_PC !== 32'h6000 + 32'(4 * k)) begin errors++; $display("FAIL b2b_order got %h exp %h", D_PC, 32'h6000 + 32'(4 * k)); end
            checks++; if (Count !== 3'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", Count); end
            tick;
        end
        F_Valid = 1'b0;
        checks++; if (Count !== 3'd2) begin errors++; $display("FAIL b2b_count_after got %0d exp 2", Count); end
        checks++; if (D_PC !== 32'h6018) begin errors++; $display("FAIL b2b_head_after got %h exp 6018", D_PC); end
        tick;
        checks++; if (D_PC !== 32'h601C) begin errors++; $display("FAIL b2b_last got %h exp 601c", D_PC); end
        checks++; if (D_Instr !== 32'h601C) begin errors++; $display("FAIL b2b_last_instr got %h exp 601c", D_Instr); end
        tick;
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL b2b_drained got %0d exp 0", Count); end
    endtask

    task automatic test_flush;
        do_reset;
        D_Stall = 1'b1; F_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            F_PC = 32'h7000 + 32'(4 * i); F_Instr = 32'h7700_0000 + 32'(i);
            tick;
        end
        checks++; if (Count !== 3'd3) begin errors++; $display("FAIL flush_prefill got %0d exp 3", Count); end
        F_PC = 32'hDEAD_0000; F_Instr = 32'h1111_1111; Flush = 1'b1;
        tick;
        Flush = 1'b0; F_Valid = 1'b0;
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", Count); end
        checks++; if (D_Valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", D_Valid); end
        checks++; if (D_Instr !== 32'h0) begin errors++; $display("FAIL flush_instr got %h exp 0", D_Instr); end
        checks++; if (D_PC8 !== 32'h8) begin errors++; $display("FAIL flush_pc8 got %h exp 8", D_PC8); end
        tick;
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL flush_dropped got %0d exp 0", Count); end
        F_Valid = 1'b1; F_PC = 32'h7100; F_Instr = 32'h2222_2222;
        tick;
        F_Valid = 1'b0;
        checks++; if (D_PC !== 32'h7100) begin errors++; $display("FAIL flush_next_pc got %h exp 7100", D_PC); end
        checks++; if (D_Instr !== 32'h2222_2222) begin errors++; $display("FAIL flush_next_instr got %h exp 22222222", D_Instr); end
        checks++; if (Count !== 3'd1) begin errors++; $display("FAIL flush_next_count got %0d exp 1", Count); end
        // Flush beats a pop the decode side would otherwise take.
        D_Stall = 1'b0; F_Valid = 1'b1; F_PC = 32'h7200; Flush = 1'b1;
        tick;
        Flush = 1'b0; F_Valid = 1'b0;
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL flush_vs_pop got %0d exp 0", Count); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        D_Stall = 1'b1; F_Valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            F_PC = 32'h8000 + 32'(4 * i); F_Instr = 32'h8800_0000 + 32'(i);
            tick;
        end
        checks++; if (Count !== 3'd4) begin errors++; $display("FAIL rstmid_prefill got %0d exp 4", Count); end
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", Count); end
        checks++; if (F_Ready !== 1'b1) begin errors++; $display("FAIL rstmid_f_ready got %b exp 1", F_Ready); end
        checks++; if (D_Valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", D_Valid); end
        F_PC = 32'h3000; F_Instr = 32'h0ABC_0123;
        tick;
        F_Valid = 1'b0;
        checks++; if (D_Valid !== 1'b1) begin errors++; $display("FAIL rstmid_push_valid got %b exp 1", D_Valid); end
        checks++; if (D_PC !== 32'h3000) begin errors++; $display("FAIL rstmid_push_pc got %h exp 3000", D_PC); end
        checks++; if (Count !== 3'd1) begin errors++; $display("FAIL rstmid_push_count got %0d exp 1", Count); end
    endtask

    task automatic test_pc8_wrap;
        do_reset;
        D_Stall = 1'b1; F_Valid = 1'b1; F_PC = 32'hFFFF_FFFC; F_Instr = 32'h0000_0001;
        tick;
        F_PC = 32'h0000_0003; F_Instr = 32'h0000_0002;
        tick;
        F_Valid = 1'b0;
        checks++; if (D_PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h exp fffffffc", D_PC); end
        checks++; if (D_PC8 !== 32'h0000_0004) begin errors++; $display("FAIL wrap_pc8 got %h exp 4", D_PC8); end
        D_Stall = 1'b0;
        tick;
        D_Stall = 1'b1;
        checks++; if (D_PC !== 32'h0000_0003) begin errors++; $display("FAIL unaligned_pc got %h exp 3", D_PC); end
        checks++; if (D_PC8 !== 32'h0000_000B) begin errors++; $display("FAIL unaligned_pc8 got %h exp b", D_PC8); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_full_stall;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        test_pc8_wrap;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
